// File: rtl/mem_arb_pkg.sv
// Shared types for the cache-line memory port arbiter.
// State encoding, burst owner encoding and word geometry.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DRAIN,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        NONE,
        DC,
        IC
    } owner_t;

    localparam int WORD_BYTES = 4;
    localparam int WORD_SHIFT = $clog2(WORD_BYTES);

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way requester picker for the memory port arbiter.
// Round robin by default; MEM_ARB_FIXED_PRIO_EN makes dcache always win.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic   d_req,
    input  logic   i_req,
    input  owner_t last_grant,
    output owner_t grant
);

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = ^last_grant;

    // dcache beats icache whenever both ask
    always_comb begin
        grant = NONE;
        if (d_req) begin
            grant = DC;
        end else if (i_req) begin
            grant = IC;
        end
    end
`else
    // on a tie, hand the port to whoever did not get it last
    always_comb begin
        grant = NONE;
        if (d_req && i_req) begin
            grant = (last_grant == DC) ? IC : DC;
        end else if (d_req) begin
            grant = DC;
        end else if (i_req) begin
            grant = IC;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one word-wide memory port between dcache and icache line engines.
// Build option MEM_ARB_FIXED_PRIO_EN: dcache wins ties instead of round robin.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDRBITS     = 32,
    parameter int DATABITS     = 32,
    parameter int LINEWORDBITS = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDRBITS-1:0] d_addr,
    input  logic [DATABITS-1:0] d_wdata,
    output logic                d_wdata_pop,
    output logic [DATABITS-1:0] d_rdata,
    output logic                d_rdata_valid,
    output logic                d_done,
    input  logic                i_req,
    input  logic [ADDRBITS-1:0] i_addr,
    output logic [DATABITS-1:0] i_rdata,
    output logic                i_rdata_valid,
    output logic                i_done,
    output logic [ADDRBITS-1:0] mem_addr,
    output logic [DATABITS-1:0] mem_in,
    output logic                mem_wrreq,
    output logic                mem_rdreq,
    input  logic [DATABITS-1:0] mem_out,
    input  logic                mem_out_valid
);

    localparam int OFFS  = LINEWORDBITS + WORD_SHIFT;
    localparam int BASEW = ADDRBITS - OFFS;
    localparam logic [LINEWORDBITS-1:0] LAST = '1;

    state_t                  state;
    owner_t                  owner;
    owner_t                  last_grant;
    owner_t                  grant;
    logic [LINEWORDBITS-1:0] cnt;
    logic [BASEW-1:0]        base;
    logic [BASEW-1:0]        sel_base;
    logic                    rd;
    logic                    wr;
    logic                    r_pend;
    logic                    d_done_q;
    logic                    i_done_q;

    // line offset bits of the request addresses are don't-care
    logic unused_offs;
    assign unused_offs = ^{d_addr[OFFS-1:0], i_addr[OFFS-1:0]};

    mem_arb_rr u_rr (
        .d_req      (d_req),
        .i_req      (i_req),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign sel_base = (grant == DC) ? d_addr[ADDRBITS-1:OFFS]
                                    : i_addr[ADDRBITS-1:OFFS];

    // burst sequencer: grant, word count, strobes and done pulse
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            owner      <= NONE;
            last_grant <= IC;
            cnt        <= '0;
            base       <= '0;
            rd         <= 1'b0;
            wr         <= 1'b0;
            r_pend     <= 1'b0;
            d_done_q   <= 1'b0;
            i_done_q   <= 1'b0;
        end else begin
            r_pend   <= rd;
            d_done_q <= 1'b0;
            i_done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant != NONE) begin
                        owner <= grant;
                        base  <= sel_base;
                        cnt   <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
                        last_grant <= grant;
`endif
                        if (grant == DC && d_we) begin
                            state <= WR_BURST;
                            wr    <= 1'b1;
                        end else begin
                            state <= RD_BURST;
                            rd    <= 1'b1;
                        end
                    end
                end
                RD_BURST: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        rd    <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WR_BURST: begin
                    if (cnt == LAST) begin
                        cnt      <= '0;
                        wr       <= 1'b0;
                        state    <= DONE;
                        d_done_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    state    <= DONE;
                    d_done_q <= (owner == DC);
                    i_done_q <= (owner == IC);
                end
                DONE: begin
                    state <= IDLE;
                    owner <= NONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign mem_rdreq   = rd;
    assign mem_wrreq   = wr;
    assign d_wdata_pop = wr;
    assign mem_in      = wr ? d_wdata : '0;
    assign mem_addr    = (rd || wr)
                       ? {base, cnt, {WORD_SHIFT{1'b0}}}
                       : '0;

    assign d_rdata_valid = r_pend && mem_out_valid && (owner == DC);
    assign i_rdata_valid = r_pend && mem_out_valid && (owner == IC);
    assign d_rdata       = d_rdata_valid ? mem_out : '0;
    assign i_rdata       = i_rdata_valid ? mem_out : '0;

    assign d_done = d_done_q;
    assign i_done = i_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 1-cycle memory model.
// Tie-break expectations follow MEM_ARB_FIXED_PRIO_EN when defined.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata;
    logic        d_wdata_pop;
    logic [31:0] d_rdata;
    logic        d_rdata_valid;
    logic        d_done;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = 32'h0;
    logic [31:0] i_rdata;
    logic        i_rdata_valid;
    logic        i_done;
    logic [31:0] mem_addr;
    logic [31:0] mem_in;
    logic        mem_wrreq;
    logic        mem_rdreq;
    logic [31:0] mem_out;
    logic        mem_out_valid;

    logic        init_mem = 1'b1;
    logic        wk_clr = 1'b1;
    logic [31:0] wbase = 32'h0;
    logic [7:0]  wk;
    logic [31:0] mem [0:255];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] rd_addrs[$];
    logic [31:0] wr_addrs[$];
    logic [31:0] wr_data[$];
    logic [31:0] d_words[$];
    logic [31:0] i_words[$];
    int done_order[$];
    int starts[$];
    int i_done_cycs[$];
    int d_done_cyc = -1;
    int i_done_cyc = -1;
    int n_dones = 0;
    int n_starts = 0;
    int n_pops = 0;
    logic prev_strobe = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDRBITS(32), .DATABITS(32), .LINEWORDBITS(3)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_wdata_pop(d_wdata_pop),
        .d_rdata(d_rdata), .d_rdata_valid(d_rdata_valid),
        .d_done(d_done),
        .i_req(i_req), .i_addr(i_addr),
        .i_rdata(i_rdata), .i_rdata_valid(i_rdata_valid),
        .i_done(i_done),
        .mem_addr(mem_addr), .mem_in(mem_in),
        .mem_wrreq(mem_wrreq), .mem_rdreq(mem_rdreq),
        .mem_out(mem_out), .mem_out_valid(mem_out_valid)
    );

    // bigmem-style memory: registered read data one cycle after rdreq
    always @(posedge clk) begin
        mem_out_valid <= mem_rdreq;
        mem_out <= mem_rdreq ? mem[mem_addr[9:2]] : 32'h0;
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h5A00_0000 | i;
        end else if (mem_wrreq) begin
            mem[mem_addr[9:2]] <= mem_in;
        end
    end

    // write-back source advancing on pop
    always @(posedge clk) begin
        if (wk_clr) wk <= 8'd0;
        else if (d_wdata_pop) wk <= wk + 8'd1;
    end
    assign d_wdata = wbase + {24'h0, wk};

    always @(posedge clk) cyc <= cyc + 1;

    // per-cycle invariants and transaction logging
    always @(negedge clk) begin
        checks++;
        if (mem_rdreq && mem_wrreq) begin
            errors++;
            $display("FAIL strobe_excl: rdreq=%b wrreq=%b, never both", mem_rdreq, mem_wrreq);
        end
        checks++;
        if (d_rdata_valid && i_rdata_valid) begin
            errors++;
            $display("FAIL valid_excl: d_valid=%b i_valid=%b, never both", d_rdata_valid, i_rdata_valid);
        end
        if (d_done || i_done) begin
            checks++;
            if (mem_rdreq || mem_wrreq) begin
                errors++;
                $display("FAIL strobe_in_done: rd=%b wr=%b, want 0", mem_rdreq, mem_wrreq);
            end
        end
        if (mem_rdreq) rd_addrs.push_back(mem_addr);
        if (mem_wrreq) begin
            wr_addrs.push_back(mem_addr);
            wr_data.push_back(mem_in);
        end
        if (d_wdata_pop) n_pops++;
        if (d_rdata_valid) d_words.push_back(d_rdata);
        if (i_rdata_valid) i_words.push_back(i_rdata);
        if (d_done) begin
            d_done_cyc = cyc;
            done_order.push_back(1);
            n_dones++;
        end
        if (i_done) begin
            i_done_cyc = cyc;
            i_done_cycs.push_back(cyc);
            done_order.push_back(2);
            n_dones++;
        end
        if ((mem_rdreq || mem_wrreq) && !prev_strobe) begin
            n_starts++;
            starts.push_back(cyc);
        end
        prev_strobe = mem_rdreq || mem_wrreq;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs;
        rd_addrs.delete();
        wr_addrs.delete();
        wr_data.delete();
        d_words.delete();
        i_words.delete();
        done_order.delete();
        starts.delete();
        i_done_cycs.delete();
    endtask

    // requester behaviour: drop req the cycle after its last wanted done
    task automatic serve(input int want_d, input int want_i, output bit timeout);
        int nd = 0;
        int ni = 0;
        timeout = 1'b1;
        for (int t = 0; t < 300; t++) begin
            tick;
            if (d_done_cyc == cyc - 1) begin
                nd++;
                if (nd >= want_d) d_req = 1'b0;
            end
            if (i_done_cyc == cyc - 1) begin
                ni++;
                if (ni >= want_i) i_req = 1'b0;
            end
            if (nd >= want_d && ni >= want_i) begin
                timeout = 1'b0;
                break;
            end
        end
        d_req = 1'b0;
        i_req = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        wbase = 32'hFFFF_0000;
        repeat (3) tick;
        @(negedge clk);
        checks++;
        if ({mem_rdreq, mem_wrreq, d_wdata_pop} !== 3'b000) begin
            errors++;
            $display("FAIL reset_strobes: got %b want 000", {mem_rdreq, mem_wrreq, d_wdata_pop});
        end
        checks++;
        if (mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_addr: got %h want 0", mem_addr);
        end
        checks++;
        if (mem_in !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem_in: got %h want 0", mem_in);
        end
        checks++;
        if ({d_done, i_done, d_rdata_valid, i_rdata_valid} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000",
                     {d_done, i_done, d_rdata_valid, i_rdata_valid});
        end
        checks++;
        if ({d_rdata, i_rdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h %h want 0", d_rdata, i_rdata);
        end
        tick;
        reset_n = 1'b1;
        init_mem = 1'b0;
        tick;
    endtask

    task automatic test_dc_fill;
        int k;
        bit to;
        clear_logs();
        tick;
        d_we = 1'b0;
        d_addr = 32'h8000_0004;
        d_req = 1'b1;
        k = cyc;
        serve(1, 0, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL fill_timeout: no d_done within budget");
        end
        checks++;
        if (rd_addrs.size() != 8) begin
            errors++;
            $display("FAIL fill_nreads: got %0d want 8", rd_addrs.size());
        end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (rd_addrs[j] !== 32'h8000_0000 + 32'(4 * j)) begin
                errors++;
                $display("FAIL fill_addr[%0d]: got %h want %h", j, rd_addrs[j], 32'h8000_0000 + 32'(4 * j));
            end
            checks++;
            if (d_words[j] !== (32'h5A00_0000 | 32'(j))) begin
                errors++;
                $display("FAIL fill_data[%0d]: got %h want %h", j, d_words[j], 32'h5A00_0000 | 32'(j));
            end
        end
        checks++;
        if (d_words.size() != 8 || i_words.size() != 0 || wr_addrs.size() != 0) begin
            errors++;
            $display("FAIL fill_counts: d=%0d i=%0d wr=%0d want 8 0 0",
                     d_words.size(), i_words.size(), wr_addrs.size());
        end
        checks++;
        if (d_done_cyc - k != 10) begin
            errors++;
            $display("FAIL fill_latency: got %0d want 10", d_done_cyc - k);
        end
        @(negedge clk);
        checks++;
        if (mem_addr !== 32'h0 || mem_rdreq !== 1'b0) begin
            errors++;
            $display("FAIL fill_idle: addr=%h rd=%b want 0 0", mem_addr, mem_rdreq);
        end
    endtask

    task automatic test_dc_writeback;
        int k;
        int p0;
        bit to;
        clear_logs();
        wbase = 32'h100;
        wk_clr = 1'b1;
        tick;
        wk_clr = 1'b0;
        d_we = 1'b1;
        d_addr = 32'h100;
        d_req = 1'b1;
        k = cyc;
        p0 = n_pops;
        serve(1, 0, to);
        checks++;
        if (to || d_done_cyc - k != 9) begin
            errors++;
            $display("FAIL wb_latency: got %0d want 9 (timeout=%b)", d_done_cyc - k, to);
        end
        checks++;
        if (wr_addrs.size() != 8 || n_pops - p0 != 8 || rd_addrs.size() != 0) begin
            errors++;
            $display("FAIL wb_counts: wr=%0d pops=%0d rd=%0d want 8 8 0",
                     wr_addrs.size(), n_pops - p0, rd_addrs.size());
        end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (wr_addrs[j] !== 32'h100 + 32'(4 * j) || wr_data[j] !== 32'h100 + 32'(j)) begin
                errors++;
                $display("FAIL wb_word[%0d]: got %h/%h want %h/%h", j, wr_addrs[j], wr_data[j],
                         32'h100 + 32'(4 * j), 32'h100 + 32'(j));
            end
        end
        clear_logs();
        d_we = 1'b0;
        d_addr = 32'h100;
        d_req = 1'b1;
        serve(1, 0, to);
        checks++;
        if (to || d_words.size() != 8) begin
            errors++;
            $display("FAIL wb_readback_count: got %0d want 8", d_words.size());
        end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (d_words[j] !== 32'h100 + 32'(j)) begin
                errors++;
                $display("FAIL wb_readback[%0d]: got %h want %h", j, d_words[j], 32'h100 + 32'(j));
            end
        end
    endtask

    task automatic test_tie;
        bit to;
        reset_n = 1'b0;
        tick;
        tick;
        reset_n = 1'b1;
        tick;
        clear_logs();
        d_we = 1'b0;
        d_addr = 32'h40;
        i_addr = 32'h80;
        d_req = 1'b1;
        i_req = 1'b1;
        serve(1, 1, to);
        checks++;
        if (to || done_order.size() != 2 || done_order[0] != 1 || done_order[1] != 2) begin
            errors++;
            $display("FAIL tie1_order: got n=%0d first=%0d want dc then ic",
                     done_order.size(), done_order[0]);
        end
        checks++;
        if (d_words[0] !== 32'h5A00_0010 || i_words[0] !== 32'h5A00_0020) begin
            errors++;
            $display("FAIL tie1_data: got %h %h want 5a000010 5a000020", d_words[0], i_words[0]);
        end
        checks++;
        if (starts.size() != 2 || starts[1] != d_done_cyc + 2) begin
            errors++;
            $display("FAIL tie1_ic_start: got %0d want %0d", starts[1], d_done_cyc + 2);
        end
        d_req = 1'b1;
        serve(1, 0, to);
        clear_logs();
        d_req = 1'b1;
        i_req = 1'b1;
        serve(1, 1, to);
        checks++;
`ifdef MEM_ARB_FIXED_PRIO_EN
        if (to || done_order.size() != 2 || done_order[0] != 1) begin
            errors++;
            $display("FAIL tie2_order: got first=%0d want 1 (dc)", done_order[0]);
        end
`else
        if (to || done_order.size() != 2 || done_order[0] != 2) begin
            errors++;
            $display("FAIL tie2_order: got first=%0d want 2 (ic)", done_order[0]);
        end
`endif
    endtask

    task automatic test_back_to_back;
        bit to;
        clear_logs();
        i_addr = 32'h300;
        i_req = 1'b1;
        serve(0, 2, to);
        checks++;
        if (to || starts.size() != 2 || i_done_cycs.size() != 2) begin
            errors++;
            $display("FAIL b2b_bursts: starts=%0d dones=%0d want 2 2", starts.size(), i_done_cycs.size());
        end
        checks++;
        if (starts[1] != i_done_cycs[0] + 2 || starts[1] - starts[0] != 11) begin
            errors++;
            $display("FAIL b2b_gap: start1=%0d done0=%0d want start1=done0+2",
                     starts[1], i_done_cycs[0]);
        end
        checks++;
        if (i_words.size() != 16 || i_words[15] !== 32'h5A00_00C7) begin
            errors++;
            $display("FAIL b2b_words: n=%0d last=%h want 16 5a0000c7", i_words.size(), i_words[15]);
        end
        clear_logs();
        i_req = 1'b1;
        tick;
        tick;
        tick;
        d_we = 1'b0;
        d_addr = 32'h40;
        d_req = 1'b1;
        serve(1, 2, to);
        checks++;
        if (to || done_order.size() != 3 || done_order[0] != 2 || done_order[1] != 1 || done_order[2] != 2) begin
            errors++;
            $display("FAIL b2b_pending_dc: got n=%0d mid=%0d want ic,dc,ic", done_order.size(), done_order[1]);
        end
    endtask

    task automatic test_reset_midburst;
        int k;
        int nd0;
        bit to;
        clear_logs();
        wbase = 32'h200;
        wk_clr = 1'b1;
        tick;
        wk_clr = 1'b0;
        d_we = 1'b1;
        d_addr = 32'h200;
        d_req = 1'b1;
        k = cyc;
        nd0 = n_dones;
        repeat (4) tick;
        @(negedge clk);
        checks++;
        if (mem_wrreq !== 1'b1 || mem_addr !== 32'h20C) begin
            errors++;
            $display("FAIL rst_word3: wr=%b addr=%h want 1 0000020c", mem_wrreq, mem_addr);
        end
        reset_n = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_wrreq, mem_rdreq, d_wdata_pop, d_done} !== 4'b0 || mem_addr !== 32'h0 || mem_in !== 32'h0) begin
            errors++;
            $display("FAIL rst_outputs: flags=%b addr=%h in=%h want 0",
                     {mem_wrreq, mem_rdreq, d_wdata_pop, d_done}, mem_addr, mem_in);
        end
        tick;
        reset_n = 1'b1;
        repeat (12) tick;
        checks++;
        if (n_dones != nd0) begin
            errors++;
            $display("FAIL rst_no_done: got %0d dones want 0", n_dones - nd0);
        end
        clear_logs();
        d_we = 1'b0;
        d_addr = 32'h200;
        d_req = 1'b1;
        k = cyc;
        serve(1, 0, to);
        checks++;
        if (to || d_words.size() != 8 || d_done_cyc - k != 10) begin
            errors++;
            $display("FAIL rst_refill: n=%0d lat=%0d want 8 10", d_words.size(), d_done_cyc - k);
        end
        for (int j = 4; j < 8; j++) begin
            checks++;
            if (d_words[j] !== (32'h5A00_0080 | 32'(j))) begin
                errors++;
                $display("FAIL rst_refill[%0d]: got %h want %h", j, d_words[j], 32'h5A00_0080 | 32'(j));
            end
        end
    endtask

    initial begin
        test_reset();
        test_dc_fill();
        test_dc_writeback();
        test_tie();
        test_back_to_back();
        test_reset_midburst();
        tick;
        checks++;
        if (n_dones != n_starts - 1) begin
            errors++;
            $display("FAIL done_per_grant: dones=%0d starts=%0d want starts-1", n_dones, n_starts);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
